uc_seq: RTL
===========

UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port opcode, input, 6 bits: instruction[15:10] from the datapath.
REQ-005 Port z, input, 1 bit: combinational ALU zero output from the datapath.
REQ-006 Port run, input, 1 bit: level; starts execution from IDLE.
REQ-007 Port step_mode, input, 1 bit: level; when high, execution pauses after each instruction.
REQ-008 Port step, input, 1 bit: single-cycle pulse that releases one instruction from PAUSE.
REQ-009 Port s_inc, output, 1 bit: 1 selects the PC+increment path, 0 selects the jump address.
REQ-010 Port s_inm, output, 1 bit: 1 selects the immediate as the register write data.
REQ-011 Port we3, output, 1 bit: register-file write enable.
REQ-012 Port s_skip, output, 1 bit: 1 selects an increment of 2.
REQ-013 Port op, output, 3 bits: ALU operation.
REQ-014 Port pc_we, output, 1 bit: PC load enable.
REQ-015 Port halted, output, 1 bit: high in state HALT.
REQ-016 Port illegal, output, 1 bit: sticky flag for an undefined opcode.
REQ-017 Port icount, output, CNT_W bits: count of retired instructions.

Function
REQ-018 The FSM states SHALL be IDLE, FETCH, EXEC, PAUSE and HALT.
REQ-019 Transitions:
- IDLE goes to FETCH when run=1.
- FETCH always goes to EXEC.
- EXEC goes to HALT on HALT or an illegal opcode.
- Otherwise EXEC goes to PAUSE if step_mode=1, else FETCH.
- PAUSE goes to FETCH when step=1.
- HALT holds until reset.
REQ-020 The throughput SHALL be one instruction per 2 cycles: FETCH lets the instruction settle, and EXEC commits it.
REQ-021 Outside EXEC, pc_we, we3, s_skip, s_inm and op SHALL be 0 and s_inc SHALL be 1.
REQ-022 In EXEC, the outputs SHALL be combinational decodes of opcode and zf, where zf is the registered flag.
REQ-023 The decode table SHALL be:
- 000ooo ALU: op=ooo, we3=1, pc_we=1.
- 001xxx LDI: s_inm=1, we3=1, pc_we=1.
- 010000 JMP: s_inc=0, pc_we=1.
- 010001 JZ: s_inc=~zf, pc_we=1.
- 010010 JNZ: s_inc=zf, pc_we=1.
- 010011 SKZ: s_skip=zf, pc_we=1.
- 011111 HALT: pc_we=0.
- All other opcodes are illegal: pc_we=0, we3=0.
REQ-024 zf SHALL load z at the end of an EXEC cycle only for ALU opcodes; it SHALL hold otherwise, including across LDI and jumps.
REQ-025 icount SHALL increment by 1 at the end of each EXEC that has pc_we=1, and SHALL wrap from all-ones to 0.
REQ-026 illegal SHALL be set at the end of an EXEC with an undefined opcode and SHALL clear only on reset.
REQ-027 When run drops after start, the block SHALL ignore it; only reset returns the FSM to IDLE.
REQ-028 step SHALL be ignored outside PAUSE; if step_mode falls while in PAUSE, the FSM SHALL still wait for step.
REQ-029 If step and step_mode are both high in EXEC, the FSM SHALL enter PAUSE, and that step SHALL NOT release it.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL set state=IDLE, zf=0, illegal=0 and icount=0, overriding every other input.
REQ-031 In the cycle that reset is asserted during EXEC, the block SHALL still drive the EXEC decode, and that edge SHALL take no effect other than reset.
REQ-032 From the following cycle, pc_we=0, we3=0, s_skip=0, s_inm=0, op=0, s_inc=1 and halted=0.

Verification
REQ-033 Reset, then run=1 with opcode=000010 and z=1 -> pc_we=1, we3=1, op=010 in cycle 2, then zf=1 and icount=1.
REQ-034 Run a JZ (010001) after an ALU instruction with z=1 -> s_inc=0 in EXEC; after an ALU instruction with z=0 -> s_inc=1.
REQ-035 Run with step_mode=1 -> the FSM stays in PAUSE with pc_we=0 for 10 cycles; one step pulse -> exactly one more EXEC, icount +1.
REQ-036 Apply opcode 111111 -> illegal=1 and halted=1, no pc_we, and icount unchanged; run toggling has no effect; reset clears both flags.
REQ-037 Preload icount to all-ones with CNT_W=4 over 16 LDI instructions -> icount wraps to 0.
REQ-038 Assert reset in the EXEC cycle of an ALU instruction -> zf and icount unchanged from their reset values, and state=IDLE on the next cycle.

Source files
------------

// File: rtl/uc_seq.sv
// Microcode sequencer: five-state fetch/execute control FSM with single-step support,
// registered zero flag, sticky illegal-opcode flag and a retired-instruction counter.
module uc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             s_skip,
    output logic [2:0]       op,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, PAUSE, HALT} state_t;

    state_t state, state_nx;
    logic   zf;
    logic   is_alu, is_halt, is_ill;

    always_comb begin
        is_alu  = 1'b0;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        casez (opcode)
            6'b000???: is_alu  = 1'b1;
            6'b001???,
            6'b010000,
            6'b010001,
            6'b010010,
            6'b010011: ;
            6'b011111: is_halt = 1'b1;
            default:   is_ill  = 1'b1;
        endcase
    end

    // Datapath controls are only live in EXEC; every other state looks like a quiet PC+1 select.
    always_comb begin
        state_nx = state;
        s_inc    = 1'b1;
        s_inm    = 1'b0;
        we3      = 1'b0;
        s_skip   = 1'b0;
        op       = 3'b000;
        pc_we    = 1'b0;
        case (state)
            IDLE:  if (run) state_nx = FETCH;
            FETCH: state_nx = EXEC;
            EXEC: begin
                casez (opcode)
                    6'b000???: begin op = opcode[2:0]; we3 = 1'b1; pc_we = 1'b1; end
                    6'b001???: begin s_inm = 1'b1; we3 = 1'b1; pc_we = 1'b1; end
                    6'b010000: begin s_inc = 1'b0; pc_we = 1'b1; end
                    6'b010001: begin s_inc = ~zf; pc_we = 1'b1; end
                    6'b010010: begin s_inc = zf; pc_we = 1'b1; end
                    6'b010011: begin s_skip = zf; pc_we = 1'b1; end
                    default: ;
                endcase
                if (is_halt || is_ill) state_nx = HALT;
                else if (step_mode)    state_nx = PAUSE;
                else                   state_nx = FETCH;
            end
            PAUSE: if (step) state_nx = FETCH;
            HALT:  state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            zf      <= 1'b0;
            illegal <= 1'b0;
            icount  <= '0;
        end else begin
            state <= state_nx;
            if (state == EXEC) begin
                if (is_alu) zf      <= z;
                if (pc_we)  icount  <= icount + CNT_W'(1);
                if (is_ill) illegal <= 1'b1;
            end
        end
    end

endmodule
